// File: rtl/mole_pkg.sv
// Shared types and score-band helpers for the whack-a-mole round scheduler.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4,
    OVER  = 3'd5
  } phase_t;

  localparam logic [7:0] BAND_LO  = 8'd5;
  localparam logic [7:0] BAND_MID = 8'd10;
  localparam logic [7:0] BAND_HI  = 8'd20;

  localparam logic [3:0] ARM_TICKS = 4'd3;

  // Rounds get shorter and busier as the score climbs.
  function automatic logic [3:0] window_ticks(input logic [7:0] score);
    if (score < BAND_LO)       return 4'd5;
    else if (score < BAND_MID) return 4'd4;
    else if (score < BAND_HI)  return 4'd3;
    else                       return 4'd2;
  endfunction

  function automatic logic [2:0] lit_count(input logic [7:0] score);
    if (score < BAND_LO)       return 3'd1;
    else if (score < BAND_MID) return 3'd2;
    else if (score < BAND_HI)  return 3'd3;
    else                       return 3'd4;
  endfunction

endpackage

// File: rtl/mole_tick_gen.sv
// Free-running prescaler: one-cycle tick strobe every TICK_DIV clk cycles.
module mole_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/mole_round_sched.sv
// Round scheduler for the whack-a-mole game: arms, issues rounds, scores, tracks lives.
// Define MOLE_WRONG_PENALTY_EN to make a wrong press in WAIT cost a life.
module mole_round_sched
  import mole_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int GAME_TICKS = 60,
  parameter int LIVES      = 3,
  parameter int GAP_TICKS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       wrong,
  output logic       round_req,
  output logic       round_active,
  output logic [2:0] num_lit,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] lives,
  output logic       game_end,
  output logic [2:0] phase
);

`ifdef MOLE_WRONG_PENALTY_EN
  localparam bit PENALTY_EN = 1'b1;
`else
  localparam bit PENALTY_EN = 1'b0;
`endif

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [15:0] GAME_INIT  = 16'(GAME_TICKS);
  localparam logic [3:0]  GAP_INIT   = 4'(GAP_TICKS);

  logic tick;

  mole_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  phase_t      state, state_nxt;
  logic        start_q;
  logic [7:0]  score_r, score_nxt;
  logic [7:0]  high_r, high_nxt;
  logic [1:0]  lives_r, lives_nxt;
  logic [15:0] gtmr, gtmr_nxt;
  logic [3:0]  ptmr, ptmr_nxt;
  logic        start_rise, game_tick, game_expire, miss;

  assign start_rise = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      score_r <= 8'd0;
      high_r  <= 8'd0;
      lives_r <= LIVES_INIT;
      gtmr    <= 16'd0;
      ptmr    <= 4'd0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      score_r <= score_nxt;
      high_r  <= high_nxt;
      lives_r <= lives_nxt;
      gtmr    <= gtmr_nxt;
      ptmr    <= ptmr_nxt;
    end
  end

  // ptmr is shared: ARM delay, round window and GAP delay never overlap.
  always_comb begin
    state_nxt   = state;
    score_nxt   = score_r;
    high_nxt    = high_r;
    lives_nxt   = lives_r;
    gtmr_nxt    = gtmr;
    ptmr_nxt    = ptmr;
    miss        = 1'b0;
    game_tick   = tick && (state == ISSUE || state == WAIT || state == GAP);
    game_expire = game_tick && (gtmr == 16'd1);
    if (game_tick) gtmr_nxt = gtmr - 16'd1;

    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_nxt = ARM;
          score_nxt = 8'd0;
          lives_nxt = LIVES_INIT;
          gtmr_nxt  = GAME_INIT;
          ptmr_nxt  = ARM_TICKS;
        end
      end
      ARM: begin
        if (tick) begin
          ptmr_nxt = ptmr - 4'd1;
          if (ptmr == 4'd1) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ptmr_nxt  = window_ticks(score_r);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (hit) begin
          if (score_r != 8'hFF) score_nxt = score_r + 8'd1;
          state_nxt = GAP;
          ptmr_nxt  = GAP_INIT;
        end else begin
          miss = (tick && ptmr == 4'd1) || (PENALTY_EN && wrong);
          if (tick) ptmr_nxt = ptmr - 4'd1;
          if (miss) begin
            lives_nxt = lives_r - 2'd1;
            if (lives_r == 2'd1) begin
              state_nxt = OVER;
            end else begin
              state_nxt = GAP;
              ptmr_nxt  = GAP_INIT;
            end
          end
        end
      end
      GAP: begin
        if (GAP_INIT == 4'd0) begin
          state_nxt = ISSUE;
        end else if (tick) begin
          ptmr_nxt = ptmr - 4'd1;
          if (ptmr == 4'd1) state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (game_expire) state_nxt = OVER;
    if (state_nxt == OVER && state != OVER && score_nxt > high_r) high_nxt = score_nxt;
  end

  assign round_req    = (state == ISSUE);
  assign round_active = (state == WAIT);
  assign game_end     = (state == OVER);
  assign phase        = state;
  assign score        = score_r;
  assign high_score   = high_r;
  assign lives        = lives_r;
  assign num_lit      = lit_count(score_r);

endmodule

// File: tb/tb_mole_round_sched.sv
// Directed bench for mole_round_sched (TICK_DIV=4, GAME_TICKS=40, LIVES=3, GAP_TICKS=1).
module tb_mole_round_sched;

  localparam int TD = 4;
  localparam logic [2:0] P_IDLE = 3'd0, P_ARM = 3'd1, P_ISSUE = 3'd2, P_WAIT = 3'd3,
                         P_GAP = 3'd4, P_OVER = 3'd5;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, hit = 1'b0, wrong = 1'b0;
  logic       round_req, round_active, game_end;
  logic [2:0] num_lit, phase;
  logic [7:0] score, high_score;
  logic [1:0] lives;

  mole_round_sched #(.TICK_DIV(TD), .GAME_TICKS(40), .LIVES(3), .GAP_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .wrong(wrong),
    .round_req(round_req), .round_active(round_active), .num_lit(num_lit),
    .score(score), .high_score(high_score), .lives(lives), .game_end(game_end),
    .phase(phase)
  );

  always #5 clk = ~clk;

  // Reference tick: free-running, cleared by reset, strobes every TD cycles.
  int   tcnt;
  logic tb_tick;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 0;
    else        tcnt <= (tcnt == TD - 1) ? 0 : tcnt + 1;
  end
  assign tb_tick = (tcnt == TD - 1);

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_issue(input string tag);
    int k = 0;
    while (round_req !== 1'b1 && k < 200) begin step(); k++; end
    check({tag, " round_req"}, 16'(round_req), 16'd1);
  endtask

  task automatic quick_hit();
    wait_issue("quick");
    step();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  task automatic lose_round(output int n);
    int k = 0;
    wait_issue("lose");
    step();
    n = 0;
    while (round_active === 1'b1 && k < 100) begin
      if (tb_tick) n++;
      step(); k++;
    end
  endtask

  task automatic start_game();
    start = 1'b0; step();
    start = 1'b1; step();
    check("start->ARM", 16'(phase), 16'(P_ARM));
  endtask

  task automatic lose_until_over();
    int n;
    for (int r = 0; r < 5; r++) begin
      if (game_end === 1'b1) break;
      lose_round(n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, k, exp_score;
    logic early;

    // Reset values
    repeat (3) step();
    check("rst phase", 16'(phase), 16'(P_IDLE));
    check("rst round_req", 16'(round_req), 16'd0);
    check("rst round_active", 16'(round_active), 16'd0);
    check("rst score", 16'(score), 16'd0);
    check("rst high", 16'(high_score), 16'd0);
    check("rst lives", 16'(lives), 16'd3);
    check("rst game_end", 16'(game_end), 16'd0);
    check("rst num_lit", 16'(num_lit), 16'd1);
    rst_n = 1'b1;
    step();

    // Game 1: arm delay, then three unanswered rounds
    start = 1'b1; step();
    check("g1 ARM", 16'(phase), 16'(P_ARM));
    n = 0; k = 0; early = 1'b0;
    while (n < 3 && k < 50) begin
      if (round_req) early = 1'b1;
      if (tb_tick) n++;
      step(); k++;
    end
    check("arm early req", 16'(early), 16'd0);
    check("arm req after 3 ticks", 16'(round_req), 16'd1);
    check("arm ISSUE", 16'(phase), 16'(P_ISSUE));
    step();
    check("req one cycle", 16'(round_req), 16'd0);
    check("round_active", 16'(round_active), 16'd1);
    n = 0; k = 0;
    while (round_active === 1'b1 && k < 100) begin
      if (tb_tick) n++;
      step(); k++;
    end
    check("g1 window s0", 16'(n), 16'd5);
    check("g1 lives 2", 16'(lives), 16'd2);
    check("g1 GAP", 16'(phase), 16'(P_GAP));
    lose_round(n);
    check("g1 lives 1", 16'(lives), 16'd1);
    lose_round(n);
    check("g1 lives 0", 16'(lives), 16'd0);
    check("g1 game_end", 16'(game_end), 16'd1);
    check("g1 OVER", 16'(phase), 16'(P_OVER));
    check("g1 high 0", 16'(high_score), 16'd0);

    // Game 2: late hit, gap timing, band 5, finish at 7
    start_game();
    check("g2 score clr", 16'(score), 16'd0);
    check("g2 lives load", 16'(lives), 16'd3);
    wait_issue("g2 r1");
    step(); step();
    hit = 1'b1; step(); hit = 1'b0;
    check("g2 hit score", 16'(score), 16'd1);
    check("g2 hit GAP", 16'(phase), 16'(P_GAP));
    n = 0; k = 0;
    while (round_req !== 1'b1 && k < 50) begin
      if (tb_tick) n++;
      step(); k++;
    end
    check("g2 gap ticks", 16'(n), 16'd1);
    repeat (4) quick_hit();
    check("g2 score 5", 16'(score), 16'd5);
    check("g2 num_lit 2", 16'(num_lit), 16'd2);
    lose_round(n);
    check("g2 window s5", 16'(n), 16'd4);
    check("g2 lives 2", 16'(lives), 16'd2);
    repeat (2) quick_hit();
    hit = 1'b1; step(); hit = 1'b0;
    check("hit outside WAIT", 16'(score), 16'd7);
    lose_until_over();
    check("g2 game_end", 16'(game_end), 16'd1);
    check("g2 score 7", 16'(score), 16'd7);
    check("g2 high 7", 16'(high_score), 16'd7);

    // Game 3: coincident hit/expiry, wrong press, lower score keeps high
    start_game();
    repeat (3) quick_hit();
    wait_issue("g3 coinc");
    step();
    n = 0; k = 0;
    while (k < 50) begin
      if (tb_tick) begin
        n++;
        if (n == 5) begin hit = 1'b1; step(); hit = 1'b0; break; end
      end
      step(); k++;
    end
    check("coinc score", 16'(score), 16'd4);
    check("coinc lives", 16'(lives), 16'd3);
    check("coinc GAP", 16'(phase), 16'(P_GAP));
    wait_issue("g3 wrong");
    step();
    wrong = 1'b1; step(); wrong = 1'b0;
`ifdef MOLE_WRONG_PENALTY_EN
    check("wrong penalty lives", 16'(lives), 16'd2);
    check("wrong penalty GAP", 16'(phase), 16'(P_GAP));
`else
    check("wrong ignored lives", 16'(lives), 16'd3);
    check("wrong ignored WAIT", 16'(phase), 16'(P_WAIT));
    k = 0;
    while (round_active === 1'b1 && k < 100) begin step(); k++; end
    check("g3 expiry lives", 16'(lives), 16'd2);
`endif
    lose_until_over();
    check("g3 game_end", 16'(game_end), 16'd1);
    check("g3 score 4", 16'(score), 16'd4);
    check("g3 high stays 7", 16'(high_score), 16'd7);

    // Game 4: climb to 20, shortest window, then end on the game timer
    start_game();
    exp_score = 0;
    for (int i = 1; i <= 20; i++) begin
      quick_hit();
      exp_score++;
      if (i == 10) check("num_lit 3", 16'(num_lit), 16'd3);
    end
    check("g4 score 20", 16'(score), 16'd20);
    check("num_lit 4", 16'(num_lit), 16'd4);
    lose_round(n);
    check("g4 window s20", 16'(n), 16'd2);
    check("g4 lives 2", 16'(lives), 16'd2);
    for (int r = 0; r < 60; r++) begin
      k = 0;
      while (round_req !== 1'b1 && game_end !== 1'b1 && k < 50) begin step(); k++; end
      if (game_end === 1'b1) break;
      step();
      if (round_active === 1'b1) begin
        hit = 1'b1; step(); hit = 1'b0;
        exp_score++;
      end
    end
    check("timer game_end", 16'(game_end), 16'd1);
    check("timer lives kept", 16'(lives), 16'd2);
    check("timer score", 16'(score), 16'(exp_score));
    check("timer high", 16'(high_score), 16'(exp_score));

    // Game 5: reset mid-game abandons everything
    start_game();
    quick_hit();
    rst_n = 1'b0;
    #1;
    check("mid rst phase", 16'(phase), 16'(P_IDLE));
    check("mid rst score", 16'(score), 16'd0);
    check("mid rst high", 16'(high_score), 16'd0);
    check("mid rst lives", 16'(lives), 16'd3);
    check("mid rst round_req", 16'(round_req), 16'd0);
    check("mid rst round_active", 16'(round_active), 16'd0);
    check("mid rst game_end", 16'(game_end), 16'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mole_round_sched.md
MOLE_ROUND_SCHED -- requirements
Module: mole_round_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, meaning clk cycles per game tick (at least 2).
REQ-002 SHALL have parameter GAME_TICKS, default 60, meaning game length in ticks (1..65535).
REQ-003 SHALL have parameter LIVES, default 3, meaning lives per game (1..3).
REQ-004 SHALL have parameter GAP_TICKS, default 1, meaning blank ticks between rounds (0..15).
REQ-005 SHALL use clock clk and reset rst_n; reset rst_n is asynchronous, active-low.
REQ-006 SHALL have port clk  in  1  system clock.
REQ-007 SHALL have port rst_n  in  1  async active-low reset.
REQ-008 SHALL have port start  in  1  level; only its rising edge is used.
REQ-009 SHALL have port hit  in  1  single-cycle pulse: player cleared the current pattern.
REQ-010 SHALL have port wrong  in  1  single-cycle pulse: player pressed a non-lit button.
REQ-011 SHALL have port round_req  out  1  single-cycle pulse: pattern generator latches a new pattern.
REQ-012 SHALL have port round_active  out  1  high while a round awaits the player.
REQ-013 SHALL have port num_lit  out  3  lit-segment count for the next pattern.
REQ-014 SHALL have port score  out  8  current score.
REQ-015 SHALL have port high_score  out  8  best score since reset.
REQ-016 SHALL have port lives  out  2  remaining lives.
REQ-017 SHALL have port game_end  out  1  high in OVER.
REQ-018 SHALL have port phase  out  3  current state encoding.

Function
REQ-019 SHALL generate tick: a one-cycle strobe every TICK_DIV clk cycles from a free-running counter.
REQ-020 SHALL implement states IDLE, ARM, ISSUE, WAIT, GAP, OVER.
REQ-021 IDLE/OVER: on a start rising edge, SHALL go to ARM, clear score, load lives=LIVES, and load game timer=GAME_TICKS; start is ignored in all other states.
REQ-022 ARM: SHALL go to ISSUE on the 3rd tick after entry.
REQ-023 ISSUE: SHALL last exactly one cycle, assert round_req, load the round window from score, then go to WAIT.
REQ-024 Round window in ticks SHALL be 5 (score<5), 4 (<10), 3 (<20), otherwise 2; num_lit SHALL be 1, 2, 3, 4 over the same bands, combinational from score.
REQ-025 WAIT: a hit SHALL increment score (saturating at 255) on the same edge and go to GAP next cycle.
REQ-026 WAIT: SHALL decrement the window on each tick; when it reaches 0 without a hit, SHALL decrement lives and go to GAP, or to OVER if lives becomes 0.
REQ-027 GAP: SHALL go to ISSUE after GAP_TICKS ticks; with GAP_TICKS=0, SHALL go to ISSUE on the next cycle.
REQ-028 Game timer SHALL decrement on each tick in ISSUE/WAIT/GAP; reaching 0 SHALL force OVER regardless of state.
REQ-029 A hit coincident with window expiry SHALL count as a hit with no life lost.
REQ-030 A hit coincident with game timer expiry SHALL increment score, then go to OVER.
REQ-031 On entering OVER, SHALL load high_score with score if score > high_score.
REQ-032 hit/wrong outside WAIT SHALL be ignored.
REQ-033 round_active SHALL equal (state==WAIT); game_end SHALL equal (state==OVER).

Reset
REQ-034 On reset SHALL set: state IDLE, round_req 0, round_active 0, score 0, high_score 0, lives LIVES, game_end 0, tick counter 0, timers 0.
REQ-035 Reset asserted mid-game SHALL abandon the game immediately; high_score SHALL also clear.

Configuration
REQ-036 With MOLE_WRONG_PENALTY_EN defined, a wrong in WAIT SHALL be treated as window expiry (life lost; hit in the same cycle wins).
REQ-037 Without MOLE_WRONG_PENALTY_EN, the wrong input SHALL be ignored.

Structure
REQ-038 Package mole_pkg SHALL hold the phase_t enum (IDLE=0, ARM=1, ISSUE=2, WAIT=3, GAP=4, OVER=5) and the score band thresholds 5/10/20.
REQ-039 The tick prescaler SHALL be sub-module mole_tick_gen; the remaining logic SHALL be in one FSM block.

Verification (TICK_DIV=4, GAME_TICKS=40, LIVES=3, GAP_TICKS=1)
REQ-040 Bench SHALL cover: start edge from IDLE -> phase ARM; one round_req pulse exactly 3 ticks later; round_active high the next cycle.
REQ-041 Bench SHALL cover: hit 2 cycles into WAIT -> score 1, phase GAP, next round_req after 1 tick.
REQ-042 Bench SHALL cover: no hit for 3 rounds -> lives 3->2->1->0, game_end=1, high_score=0.
REQ-043 Bench SHALL cover: score driven to 5 -> round window 4 ticks, num_lit=2; at score 20 -> window 2 ticks, num_lit=4.
REQ-044 Bench SHALL cover: hit and window expiry in the same cycle -> score +1, lives unchanged.
REQ-045 Bench SHALL cover: game over with score 7, restart, game over with score 4 -> high_score stays 7; rst_n pulse mid-game -> all outputs at reset values; with the macro defined, wrong in WAIT -> lives decrement.
